// File: rtl/demux2_stream.sv
// demux2_stream: streaming 1-to-2 demultiplexer.
//   A valid/ready input word is routed by cmd (0 -> q0, 1 -> q1) into one of
//   two 2-entry FIFOs, each with its own valid/ready output handshake.
//   Saturating per-output counters track words accepted toward each side.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   i, cmd             - input word and its route select
//   i_valid, i_ready   - input handshake (i_ready combinational)
//   q0/q1, qN_valid    - FIFO head word and non-empty flag
//   qN_ready           - consumer N takes the head this cycle
//   cnt0, cnt1         - saturating accepted-word counters per output

// Two-entry FIFO with a registered head; head holds its last value when empty.
module demux2_stream_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_push,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_pop
);
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_cnt;
    logic             w_pop;

    assign w_pop   = (r_cnt != 2'd0) && i_rdy;
    assign o_pop   = w_pop;
    assign o_data  = r_head;
    assign o_valid = (r_cnt != 2'd0);
    assign o_full  = (r_cnt == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b11: begin
                    // Count unchanged; head advances to the next word in order.
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else begin
                        r_head <= i_data;
                    end
                end
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= i_data;
                        r_cnt  <= 2'd1;
                    end else begin
                        r_tail <= i_data;
                        r_cnt  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_cnt <= r_cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

module demux2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             cmd,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [WIDTH-1:0] q0,
    output logic             q0_valid,
    input  logic             q0_ready,
    output logic [WIDTH-1:0] q1,
    output logic             q1_valid,
    input  logic             q1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    logic             w_full0;
    logic             w_full1;
    logic             w_pop0;
    logic             w_pop1;
    logic             w_acc;
    logic             w_push0;
    logic             w_push1;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // A full FIFO can still take a word when it is popping in the same cycle.
    assign i_ready = !rst && (cmd ? (!w_full1 || w_pop1) : (!w_full0 || w_pop0));
    assign w_acc   = i_valid && i_ready;
    assign w_push0 = w_acc && !cmd;
    assign w_push1 = w_acc && cmd;

    demux2_stream_fifo #(.WIDTH(WIDTH)) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i),
        .i_push  (w_push0),
        .i_rdy   (q0_ready),
        .o_data  (q0),
        .o_valid (q0_valid),
        .o_full  (w_full0),
        .o_pop   (w_pop0)
    );

    demux2_stream_fifo #(.WIDTH(WIDTH)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i),
        .i_push  (w_push1),
        .i_rdy   (q1_ready),
        .o_data  (q1),
        .o_valid (q1_valid),
        .o_full  (w_full1),
        .o_pop   (w_pop1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_push0 && (r_cnt0 != '1)) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_push1 && (r_cnt1 != '1)) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
endmodule
